// File: rtl/page_sequencer.sv
// Page sequencer: turns a multi-page request into a stream of {block, page} row
// addresses and steers the external page-address timer. Optional abort: SEQ_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for Seq_Start; request inputs sampled here only
// LOAD    | clear timer to the first page of the request
// PRESENT | row address offered to the consumer, one page per accept
// DONE    | one-cycle Seq_Done pulse, then back to IDLE
module page_sequencer #(
    parameter int PAGE_BITS  = 6,
    parameter int BLOCK_BITS = 10,
    parameter int CNT_BITS   = 16
) (
    input  logic                          clk2,
    input  logic                          Reset,
    input  logic                          Seq_Start,
    input  logic [BLOCK_BITS-1:0]         Seq_StartBlock,
    input  logic [PAGE_BITS-1:0]          Seq_StartPage,
    input  logic [CNT_BITS-1:0]           Seq_NumPages,
`ifdef SEQ_ABORT_EN
    input  logic                          Seq_Abort,
    output logic                          Seq_Aborted,
`endif
    output logic                          Seq_Busy,
    output logic                          Seq_Done,
    output logic                          Row_Valid,
    input  logic                          Row_Ready,
    output logic [BLOCK_BITS+PAGE_BITS-1:0] Row_Addr,
    output logic                          Row_Last,
    output logic                          AddTimer_Ena,
    output logic                          AddTimer_Clear,
    output logic [PAGE_BITS-1:0]          AddTimer_StartValue,
    output logic [PAGE_BITS-1:0]          Rollover_Value,
    input  logic [PAGE_BITS-1:0]          CurrentAdd,
    input  logic                          AddTimer_Rollover
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   remaining_q, remaining_d;
    logic [BLOCK_BITS-1:0] block_q, block_d;
    logic [PAGE_BITS-1:0]  start_page_q, start_page_d;
    logic                  is_last;

`ifdef SEQ_ABORT_EN
    logic aborted_q, aborted_d;
`endif

    assign Rollover_Value = {PAGE_BITS{1'b1}};
    assign is_last        = (remaining_q == CNT_BITS'(1));

    always_ff @(posedge clk2) begin
        if (Reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            block_q      <= '0;
            start_page_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            block_q      <= block_d;
            start_page_q <= start_page_d;
        end
    end

`ifdef SEQ_ABORT_EN
    always_ff @(posedge clk2) begin
        if (Reset) aborted_q <= 1'b0;
        else       aborted_q <= aborted_d;
    end

    assign Seq_Aborted = (state_q == DONE) && aborted_q;
`endif

    always_comb begin
        state_d             = state_q;
        remaining_d         = remaining_q;
        block_d             = block_q;
        start_page_d        = start_page_q;
        Seq_Busy            = (state_q != IDLE);
        Seq_Done            = 1'b0;
        Row_Valid           = 1'b0;
        Row_Addr            = '0;
        Row_Last            = 1'b0;
        AddTimer_Ena        = 1'b0;
        AddTimer_Clear      = 1'b0;
        AddTimer_StartValue = '0;
`ifdef SEQ_ABORT_EN
        aborted_d           = aborted_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef SEQ_ABORT_EN
                aborted_d = 1'b0;
`endif
                if (Seq_Start) begin
                    if (Seq_NumPages != '0) begin
                        block_d      = Seq_StartBlock;
                        remaining_d  = Seq_NumPages;
                        start_page_d = Seq_StartPage;
                        state_d      = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            LOAD: begin
`ifdef SEQ_ABORT_EN
                if (Seq_Abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else
`endif
                begin
                    AddTimer_Clear      = 1'b1;
                    AddTimer_StartValue = start_page_q;
                    state_d             = PRESENT;
                end
            end

            PRESENT: begin
                Row_Valid = 1'b1;
                Row_Addr  = {block_q, CurrentAdd};
                Row_Last  = is_last;
                if (Row_Ready)
                    remaining_d = remaining_q - CNT_BITS'(1);
`ifdef SEQ_ABORT_EN
                // An abort still counts a coincident accept, but leaves the timer alone.
                if (Seq_Abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else
`endif
                if (Row_Ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (AddTimer_Rollover) begin
                        // Last page of the block: restart the timer and move to the next block.
                        AddTimer_Clear      = 1'b1;
                        AddTimer_StartValue = '0;
                        block_d             = block_q + BLOCK_BITS'(1);
                    end else begin
                        AddTimer_Ena = 1'b1;
                    end
                end
            end

            DONE: begin
                Seq_Done = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_page_sequencer.sv
// Directed self-checking bench for page_sequencer, with a behavioural page timer
// closing the loop on AddTimer_* / CurrentAdd.
module tb_page_sequencer;

    localparam int PB = 6;
    localparam int BB = 10;
    localparam int CB = 16;

    logic          clk2 = 1'b0;
    logic          Reset;
    logic          Seq_Start;
    logic [BB-1:0] Seq_StartBlock;
    logic [PB-1:0] Seq_StartPage;
    logic [CB-1:0] Seq_NumPages;
    logic          Seq_Busy, Seq_Done, Row_Valid, Row_Ready, Row_Last;
    logic [BB+PB-1:0] Row_Addr;
    logic          AddTimer_Ena, AddTimer_Clear, AddTimer_Rollover;
    logic [PB-1:0] AddTimer_StartValue, Rollover_Value, CurrentAdd;
`ifdef SEQ_ABORT_EN
    logic          Seq_Abort;
    logic          Seq_Aborted;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk2 = ~clk2;

    page_sequencer #(.PAGE_BITS(PB), .BLOCK_BITS(BB), .CNT_BITS(CB)) dut (
        .clk2               (clk2),
        .Reset              (Reset),
        .Seq_Start          (Seq_Start),
        .Seq_StartBlock     (Seq_StartBlock),
        .Seq_StartPage      (Seq_StartPage),
        .Seq_NumPages       (Seq_NumPages),
`ifdef SEQ_ABORT_EN
        .Seq_Abort          (Seq_Abort),
        .Seq_Aborted        (Seq_Aborted),
`endif
        .Seq_Busy           (Seq_Busy),
        .Seq_Done           (Seq_Done),
        .Row_Valid          (Row_Valid),
        .Row_Ready          (Row_Ready),
        .Row_Addr           (Row_Addr),
        .Row_Last           (Row_Last),
        .AddTimer_Ena       (AddTimer_Ena),
        .AddTimer_Clear     (AddTimer_Clear),
        .AddTimer_StartValue(AddTimer_StartValue),
        .Rollover_Value     (Rollover_Value),
        .CurrentAdd         (CurrentAdd),
        .AddTimer_Rollover  (AddTimer_Rollover)
    );

    // Downstream page timer: clear beats enable, count is registered.
    always @(posedge clk2) begin
        if (Reset)               CurrentAdd <= '0;
        else if (AddTimer_Clear) CurrentAdd <= AddTimer_StartValue;
        else if (AddTimer_Ena)   CurrentAdd <= CurrentAdd + 6'd1;
    end
    assign AddTimer_Rollover = (CurrentAdd == 6'd63);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic check_row(input string tag, input logic valid, input logic [15:0] addr,
                             input logic last, input logic ena, input logic clr);
        check({tag, "_valid"}, 32'(Row_Valid), 32'(valid));
        check({tag, "_addr"},  32'(Row_Addr), 32'(addr));
        check({tag, "_last"},  32'(Row_Last), 32'(last));
        check({tag, "_ena"},   32'(AddTimer_Ena), 32'(ena));
        check({tag, "_clr"},   32'(AddTimer_Clear), 32'(clr));
    endtask

    task automatic request(input logic [BB-1:0] blk, input logic [PB-1:0] pg, input logic [CB-1:0] n);
        Seq_Start      = 1'b1;
        Seq_StartBlock = blk;
        Seq_StartPage  = pg;
        Seq_NumPages   = n;
    endtask

    initial begin
        Reset = 1'b1; Seq_Start = 1'b0; Seq_StartBlock = '0; Seq_StartPage = '0;
        Seq_NumPages = '0; Row_Ready = 1'b0;
`ifdef SEQ_ABORT_EN
        Seq_Abort = 1'b0;
`endif
        tick(); tick(); #1;
        check("rst_busy", 32'(Seq_Busy), 0);
        check("rst_done", 32'(Seq_Done), 0);
        check_row("rst", 0, 16'h0, 0, 0, 0);
        check("rst_sv", 32'(AddTimer_StartValue), 0);
        check("rst_rollval", 32'(Rollover_Value), 63);
        Reset = 1'b0;

        // Block 5, page 10, three pages, Ready held high
        tick(); request(5, 10, 3); Row_Ready = 1'b1; #1;
        check("t1_idle_busy", 32'(Seq_Busy), 0);
        check("t1_idle_ready_ena", 32'(AddTimer_Ena), 0);
        tick(); Seq_Start = 1'b0; #1;
        check("t1_load_clr", 32'(AddTimer_Clear), 1);
        check("t1_load_sv", 32'(AddTimer_StartValue), 10);
        check("t1_load_valid", 32'(Row_Valid), 0);
        check("t1_load_busy", 32'(Seq_Busy), 1);
        tick(); #1; check_row("t1_r0", 1, 16'h14A, 0, 1, 0);
        tick(); #1; check_row("t1_r1", 1, 16'h14B, 0, 1, 0);
        tick(); #1; check_row("t1_r2", 1, 16'h14C, 1, 0, 0);
        tick(); #1;
        check("t1_done", 32'(Seq_Done), 1);
        check("t1_done_valid", 32'(Row_Valid), 0);
        tick(); #1;
        check("t1_done_gone", 32'(Seq_Done), 0);
        check("t1_idle_again", 32'(Seq_Busy), 0);

        // Block 2, page 62, four pages, crossing into block 3
        request(2, 62, 4); #1;
        tick(); Seq_Start = 1'b0; #1;
        check("t2_load_sv", 32'(AddTimer_StartValue), 62);
        tick(); #1; check_row("t2_r0", 1, 16'd190, 0, 1, 0);
        tick(); request(0, 0, 0); #1;
        check_row("t2_r1", 1, 16'd191, 0, 0, 1);
        check("t2_r1_sv", 32'(AddTimer_StartValue), 0);
        tick(); Seq_Start = 1'b0; #1; check_row("t2_r2", 1, 16'd192, 0, 1, 0);
        tick(); #1; check_row("t2_r3", 1, 16'd193, 1, 0, 0);
        tick(); #1; check("t2_done", 32'(Seq_Done), 1);
        tick(); #1;

        // Block index wraps from 1023 to 0
        request(1023, 63, 2); #1;
        tick(); Seq_Start = 1'b0; #1;
        tick(); #1; check_row("t3_r0", 1, 16'hFFFF, 0, 0, 1);
        tick(); #1; check_row("t3_r1", 1, 16'h0000, 1, 0, 0);
        tick(); #1; check("t3_done", 32'(Seq_Done), 1);
        tick(); #1;

        // Backpressure: Ready 0,0,1,0,1 on block 7, page 5, two pages
        request(7, 5, 2); Row_Ready = 1'b0; #1;
        tick(); Seq_Start = 1'b0; #1;
        tick(); #1; check_row("t4_s0", 1, 16'd453, 0, 0, 0);
        tick(); #1; check_row("t4_s1", 1, 16'd453, 0, 0, 0);
        tick(); Row_Ready = 1'b1; #1; check_row("t4_a0", 1, 16'd453, 0, 1, 0);
        tick(); Row_Ready = 1'b0; #1; check_row("t4_s2", 1, 16'd454, 1, 0, 0);
        tick(); Row_Ready = 1'b1; #1; check_row("t4_a1", 1, 16'd454, 1, 0, 0);
        tick(); #1;
        check("t4_done", 32'(Seq_Done), 1);
        check("t4_done_valid", 32'(Row_Valid), 0);
        tick(); #1;

        // Zero-length request
        request(3, 3, 0); #1;
        tick(); Seq_Start = 1'b0; #1;
        check("t5_done", 32'(Seq_Done), 1);
        check("t5_valid", 32'(Row_Valid), 0);
        check("t5_clr", 32'(AddTimer_Clear), 0);
        tick(); #1;
        check("t5_idle", 32'(Seq_Busy), 0);
        check("t5_done_gone", 32'(Seq_Done), 0);

        // Reset while presenting rows
        request(4, 0, 5); #1;
        tick(); Seq_Start = 1'b0; #1;
        tick(); #1; check_row("t6_r0", 1, 16'h100, 0, 1, 0);
        tick(); Reset = 1'b1; #1;
        check_row("t6_r1", 1, 16'h101, 0, 1, 0);
        tick(); #1;
        check_row("t6_rst", 0, 16'h0, 0, 0, 0);
        check("t6_rst_busy", 32'(Seq_Busy), 0);
        check("t6_rst_done", 32'(Seq_Done), 0);
        Reset = 1'b0;
        tick(); #1;
        check("t6_post_done", 32'(Seq_Done), 0);
        check("t6_post_busy", 32'(Seq_Busy), 0);

`ifdef SEQ_ABORT_EN
        // Abort coinciding with the third accept of a ten-page request
        request(0, 0, 10); #1;
        tick(); Seq_Start = 1'b0; #1;
        tick(); #1; check_row("t7_r0", 1, 16'd0, 0, 1, 0);
        tick(); #1; check_row("t7_r1", 1, 16'd1, 0, 1, 0);
        tick(); Seq_Abort = 1'b1; #1; check_row("t7_r2", 1, 16'd2, 0, 0, 0);
        tick(); Seq_Abort = 1'b0; #1;
        check("t7_done", 32'(Seq_Done), 1);
        check("t7_aborted", 32'(Seq_Aborted), 1);
        check("t7_valid", 32'(Row_Valid), 0);
        tick(); #1;
        check("t7_done_gone", 32'(Seq_Done), 0);
        check("t7_aborted_gone", 32'(Seq_Aborted), 0);
        check("t7_valid_gone", 32'(Row_Valid), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
